// File: rtl/wb_cmd_sequencer.sv
// Queues Wishbone-style commands in a small FIFO and replays them one at a time
// through a start/active master handshake, returning one held response per command.
module wb_cmd_sequencer #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [aw-1:0] cmd_addr,
  input  logic [3:0]    cmd_sel,
  input  logic [dw-1:0] cmd_data,
  output logic          mst_start,
  output logic [aw-1:0] mst_address,
  output logic [3:0]    mst_selection,
  output logic          mst_write,
  output logic [dw-1:0] mst_data_wr,
  input  logic          mst_active,
  input  logic [dw-1:0] mst_data_rd,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [dw-1:0] rsp_data,
  output logic          rsp_write,
  output logic          rsp_timeout,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 1 + aw + 4 + dw;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   tmo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign pop        = (state == IDLE) && !fifo_empty && !mst_active;
  // A full FIFO still takes a command in the cycle its head is popped.
  assign cmd_ready  = !fifo_full || pop;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = !fifo_empty || (state != IDLE);

  // Command storage: payload only, pointers below qualify it
  always_ff @(posedge wb_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_sel, cmd_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Transaction sequencer with registered master and response outputs
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      mst_start     <= 1'b0;
      mst_address   <= '0;
      mst_selection <= '0;
      mst_write     <= 1'b0;
      mst_data_wr   <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_write     <= 1'b0;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {mst_write, mst_address, mst_selection, mst_data_wr} <= head;
            mst_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mst_start <= 1'b0;
          tmo_cnt   <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // The master may not have raised active yet in the first WAIT cycle.
          if ((tmo_cnt != 16'd0) && !mst_active) begin
            rsp_valid     <= 1'b1;
            rsp_data      <= mst_write ? '0 : mst_data_rd;
            rsp_write     <= mst_write;
            rsp_timeout   <= 1'b0;
            mst_address   <= '0;
            mst_selection <= '0;
            mst_write     <= 1'b0;
            mst_data_wr   <= '0;
            state         <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid     <= 1'b1;
            rsp_data      <= '0;
            rsp_write     <= mst_write;
            rsp_timeout   <= 1'b1;
            mst_address   <= '0;
            mst_selection <= '0;
            mst_write     <= 1'b0;
            mst_data_wr   <= '0;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_write   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Directed bench for wb_cmd_sequencer with a small start/active master model.
module tb_wb_cmd_sequencer;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_sel;
  logic [DW-1:0] cmd_data;
  logic          mst_start;
  logic [AW-1:0] mst_address;
  logic [3:0]    mst_selection;
  logic          mst_write;
  logic [DW-1:0] mst_data_wr;
  logic          mst_active;
  logic [DW-1:0] mst_data_rd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_write;
  logic          rsp_timeout;
  logic          busy;

  wb_cmd_sequencer #(.dw(DW), .aw(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .mst_start(mst_start), .mst_address(mst_address), .mst_selection(mst_selection),
    .mst_write(mst_write), .mst_data_wr(mst_data_wr), .mst_active(mst_active),
    .mst_data_rd(mst_data_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_write(rsp_write), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master model: raises active on start, drops it mdl_hold cycles later
  int            mdl_hold    = 3;
  bit            mdl_hang    = 1'b0;
  bit            mdl_kill    = 1'b0;
  logic [DW-1:0] mdl_rdata   = '0;
  int            act_cnt     = 0;
  int            start_cnt   = 0;
  int            overlap_cnt = 0;
  logic          prev_start  = 1'b0;
  logic [AW-1:0] log_addr [64];
  logic [DW-1:0] log_data [64];

  initial begin
    mst_active  = 1'b0;
    mst_data_rd = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (mst_start) begin
        if (rsp_valid || prev_start || mst_active) overlap_cnt++;
        if (start_cnt < 64) begin
          log_addr[start_cnt] = mst_address;
          log_data[start_cnt] = mst_data_wr;
        end
        start_cnt++;
        mst_active = 1'b1;
        act_cnt    = mdl_hold;
      end else if (mdl_kill) begin
        mst_active = 1'b0;
      end else if (mst_active && !mdl_hang) begin
        if (act_cnt > 1) begin
          act_cnt--;
        end else begin
          mst_active  = 1'b0;
          mst_data_rd = mdl_rdata;
        end
      end
      prev_start = mst_start;
    end
  end

  task automatic tick();
    @(posedge wb_clk);
    #3;
  endtask

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [3:0] s,
                          input logic [DW-1:0] d);
    int k;
    cmd_write = w;
    cmd_addr  = a;
    cmd_sel   = s;
    cmd_data  = d;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("push_ready_bound", 64'd0, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int k;
    k = 0;
    while (!rsp_valid && k < 100) begin
      tick();
      k++;
    end
    check(tag, rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int cyc;
    int base;
    int sc;
    wb_rst_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_sel   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mst_start", mst_start, 0);
    check("rst_mst_address", mst_address, 0);
    wb_rst_n = 1'b1;
    tick();

    // Single write; start pulse two edges after the push edge
    cmd_write = 1'b1;
    cmd_addr  = 32'h10;
    cmd_sel   = 4'hF;
    cmd_data  = 32'hDEADBEEF;
    cmd_valid = 1'b1;
    check("wr_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("wr_no_early_start", mst_start, 0);
    check("wr_busy", busy, 1);
    tick();
    check("wr_start", mst_start, 1);
    check("wr_addr", mst_address, 32'h10);
    check("wr_sel", mst_selection, 4'hF);
    check("wr_dir", mst_write, 1);
    check("wr_data", mst_data_wr, 32'hDEADBEEF);
    tick();
    check("wr_start_one_cycle", mst_start, 0);
    check("wr_addr_stable", mst_address, 32'h10);
    wait_rsp("wr_rsp_seen");
    check("wr_rsp_write", rsp_write, 1);
    check("wr_rsp_data", rsp_data, 0);
    check("wr_rsp_timeout", rsp_timeout, 0);
    check("wr_addr_zero_in_resp", mst_address, 0);
    check("wr_start_count", start_cnt, 1);
    take_rsp();
    check("wr_rsp_cleared", rsp_valid, 0);
    check("wr_idle_busy", busy, 0);

    // Single read
    mdl_rdata = 32'h12345678;
    push_cmd(1'b0, 32'h20, 4'hF, 32'hFFFFFFFF);
    wait_rsp("rd_rsp_seen");
    check("rd_rsp_data", rsp_data, 32'h12345678);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_timeout", rsp_timeout, 0);
    check("rd_start_count", start_cnt, 2);
    take_rsp();

    // Timeout: master never releases active
    mdl_hang  = 1'b1;
    mdl_rdata = 32'hCAFEF00D;
    push_cmd(1'b0, 32'h30, 4'h3, 32'h0);
    k = 0;
    while (!mst_start && k < 10) begin
      tick();
      k++;
    end
    check("tmo_start", mst_start, 1);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("tmo_latency", cyc, 11);
    check("tmo_flag", rsp_timeout, 1);
    check("tmo_rsp_data", rsp_data, 0);
    check("tmo_rsp_write", rsp_write, 0);
    take_rsp();
    mdl_hang = 1'b0;
    repeat (6) tick();
    check("tmo_idle_busy", busy, 0);

    // Fill the FIFO behind a held response, then push and pop at full
    base = start_cnt;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
    end
    check("full_cmd_ready_low", cmd_ready, 0);
    repeat (15) tick();
    check("full_rsp_pending", rsp_valid, 1);
    check("full_one_start", start_cnt - base, 1);
    check("full_still_blocked", cmd_ready, 0);
    check("full_busy", busy, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("full_ready_on_pop", cmd_ready, 1);
    cmd_write = 1'b1;
    cmd_addr  = 32'h114;
    cmd_sel   = 4'hF;
    cmd_data  = 32'hA0000005;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("full_pop_start", mst_start, 1);
    check("full_pop_addr", mst_address, 32'h104);
    check("full_count_kept", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("drain_rsp_seen");
      check("drain_rsp_write", rsp_write, 1);
      check("drain_rsp_timeout", rsp_timeout, 0);
      take_rsp();
    end
    check("drain_start_count", start_cnt - base, 6);
    for (int i = 0; i < 6; i++) begin
      check("order_addr", log_addr[base + i], 32'h100 + 32'(4 * i));
      check("order_data", log_data[base + i], 32'hA0000000 + 32'(i));
    end
    check("drain_idle_busy", busy, 0);

    // Reset in WAIT with two commands queued and a push in the same cycle
    mdl_hang = 1'b1;
    push_cmd(1'b1, 32'h200, 4'h1, 32'h11);
    push_cmd(1'b1, 32'h204, 4'h2, 32'h22);
    push_cmd(1'b0, 32'h208, 4'h4, 32'h33);
    repeat (2) tick();
    check("rstw_busy_before", busy, 1);
    sc        = start_cnt;
    wb_rst_n  = 1'b0;
    cmd_write = 1'b1;
    cmd_addr  = 32'h300;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rstw_busy", busy, 0);
    check("rstw_rsp_valid", rsp_valid, 0);
    check("rstw_cmd_ready", cmd_ready, 1);
    check("rstw_mst_start", mst_start, 0);
    check("rstw_mst_address", mst_address, 0);
    wb_rst_n = 1'b1;
    mdl_hang = 1'b0;
    mdl_kill = 1'b1;
    repeat (20) tick();
    check("rstw_no_more_start", start_cnt, sc);
    check("rstw_busy_after", busy, 0);
    check("rstw_rsp_after", rsp_valid, 0);
    mdl_kill = 1'b0;

    check("no_overlapping_start", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_cmd_sequencer.md
WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 Parameters SHALL be: dw, default 32, data width; aw, default 32, address width; DEPTH, default 4, command FIFO entries (power of 2, >=2); TIMEOUT, default 255, maximum wait cycles per transaction (1..65535).
REQ-002 Ports SHALL be, one per line, clock and reset first:
  wb_clk  in  1  sole clock; all state on rising edge
  wb_rst_n  in  1  synchronous active-low reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  FIFO can accept a command
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  aw  transaction address
  cmd_sel  in  4  byte selects
  cmd_data  in  dw  write data (ignored for reads)
  mst_start  out  1  one-cycle start pulse to the downstream bus master
  mst_address  out  aw  address to the master
  mst_selection  out  4  byte selects to the master
  mst_write  out  1  direction to the master
  mst_data_wr  out  dw  write data to the master
  mst_active  in  1  master busy flag
  mst_data_rd  in  dw  master read data
  rsp_valid  out  1  response held
  rsp_ready  in  1  response consumed
  rsp_data  out  dw  read data (0 for writes)
  rsp_write  out  1  direction of the completed command
  rsp_timeout  out  1  transaction exceeded TIMEOUT
  busy  out  1  FIFO non-empty or FSM not IDLE

Function
REQ-003 Command FIFO SHALL push {cmd_write,cmd_addr,cmd_sel,cmd_data} when cmd_valid && cmd_ready; cmd_ready = !full.
REQ-004 Simultaneous push and pop SHALL be permitted when full; count unchanged, no entry lost.
REQ-005 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-007 IDLE: if FIFO non-empty and mst_active==0, pop head into holding registers, go to ISSUE next cycle.
REQ-008 ISSUE: mst_start=1 for exactly this one cycle, mst_address/selection/write/data_wr driven from holding registers; go to WAIT.
REQ-009 mst_address/selection/write/data_wr SHALL hold stable from ISSUE until leaving WAIT; 0 in IDLE and RESP.
REQ-010 WAIT: the first cycle SHALL ignore mst_active; afterwards mst_active==0 means completion: capture rsp_data = write ? 0 : mst_data_rd, rsp_write, rsp_timeout=0, go to RESP.
REQ-011 WAIT timeout: 16-bit counter cleared on WAIT entry, increments each WAIT cycle; on reaching TIMEOUT without completion, capture rsp_data=0, rsp_timeout=1, go to RESP.
REQ-012 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-013 RESP: rsp_valid=1, rsp_* held stable until rsp_ready; on rsp_valid && rsp_ready go to IDLE; next command issue no earlier than the following cycle.
REQ-014 Latency SHALL be: push at cycle N into empty FIFO with idle master -> mst_start at N+2.
REQ-015 At most one transaction SHALL be outstanding; mst_start SHALL never assert while mst_active==1 in IDLE.
REQ-016 busy SHALL be 1 whenever FIFO count>0 or state!=IDLE.

Reset
REQ-017 wb_rst_n==0 at a rising edge SHALL, regardless of state, set state IDLE, FIFO empty, timeout counter 0, and all outputs 0 except cmd_ready=1; in-flight command and response are discarded.
REQ-018 Reset SHALL take priority over push, pop and rsp handshake in the same cycle.

Verification
REQ-019 Write cmd addr 0x10, sel 0xF, data 0xDEADBEEF; master model drops active 3 cycles after start -> one mst_start pulse with those values, rsp_valid with rsp_write=1, rsp_data=0, rsp_timeout=0.
REQ-020 Read cmd addr 0x20; model returns 0x12345678 -> rsp_data=0x12345678, rsp_write=0.
REQ-021 Push 5 cmds with DEPTH=4 while rsp_ready=0 -> cmd_ready low after 4th queued; ordering preserved; no mst_start while rsp_valid pending.
REQ-022 Model never drops active, TIMEOUT=10 -> rsp_timeout=1, rsp_data=0, 10 WAIT cycles after ISSUE.
REQ-023 Assert wb_rst_n=0 during WAIT with 2 queued -> next cycle busy=0, rsp_valid=0, cmd_ready=1, no further mst_start.
REQ-024 Push and pop in the same cycle at full -> count stays DEPTH, both commands later issued in order.
